// File: rtl/serial_link_pkg.sv
// Shared definitions for the flop-based serial link (PISO transmitter and
// SIPO receiver).
//   state_t      : transmitter FSM encoding (IDLE=0, SHIFT=1)
//   SDOUT_IDLE   : level driven on sdout whenever no word is on the line
//   SDOUT_N_IDLE : complementary idle level for sdout_n
package serial_link_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic SDOUT_IDLE   = 1'b0;
  localparam logic SDOUT_N_IDLE = ~SDOUT_IDLE;

endpackage

// File: rtl/comp_out_reg.sv
// Complementary output register: holds a bit and its inverse in two flops so
// the pair leaves the block glitch-free and is never equal.
// Ports:
//   clk   in  1  clock, posedge
//   reset in  1  synchronous, active-high; q=SDOUT_IDLE, q_n=~SDOUT_IDLE
//   en    in  1  load d into the pair when high
//   d     in  1  next data bit
//   q     out 1  registered data
//   q_n   out 1  registered inverse of q
module comp_out_reg
  import serial_link_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q,
  output logic q_n
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= SDOUT_IDLE;
      q_n <= SDOUT_N_IDLE;
    end else if (en) begin
      q   <= d;
      q_n <= ~d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter. Takes a WIDTH-bit word over a
// valid/ready load handshake and sends it MSB-first, one bit per shift_en
// tick, on a registered complementary pair.
//
// Handshake: a word transfers on a posedge where load_valid && load_ready;
// load_ready is high only in IDLE and does not depend on load_valid. The
// source keeps load_valid/load_data stable until the transfer happens.
//
// Ports:
//   clk        in  1      clock, posedge
//   reset      in  1      synchronous, active-high; aborts any word in flight
//   load_valid in  1      source offers load_data
//   load_ready out 1      block can accept a word (state == IDLE)
//   load_data  in  WIDTH  parallel word, sampled on accept
//   shift_en   in  1      bit-rate tick, advances one bit while in SHIFT
//   sdout      out 1      serial data, registered
//   sdout_n    out 1      registered complement of sdout
//   frame      out 1      high while a word's bits are on sdout
//   done       out 1      one-cycle pulse after the last bit slot ends
//   dbg_state  out state  current FSM state, for observation only
module piso_serial_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sdout,
  output logic             sdout_n,
  output logic             frame,
  output logic             done,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             out_en;
  logic             out_d;

  assign load_ready = (state_q == IDLE);
  assign frame      = frame_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // cnt counts bits still to send after the one currently on sdout, so
  // cnt==0 means the bit on the line is the last one of the word.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    out_en  = 1'b0;
    out_d   = SDOUT_IDLE;
    case (state_q)
      IDLE: begin
        // shift_en is deliberately not looked at here: the accept cycle
        // only presents the MSB.
        if (load_valid) begin
          state_d = SHIFT;
          shreg_d = load_data;
          cnt_d   = CW'(WIDTH - 1);
          frame_d = 1'b1;
          out_en  = 1'b1;
          out_d   = load_data[WIDTH-1];
        end
      end
      SHIFT: begin
        if (shift_en) begin
          out_en = 1'b1;
          if (cnt_q != '0) begin
            // Bit that moves into the MSB position is the next one to send.
            // The fill bit at the LSB never reaches sdout before the word
            // ends, so the old MSB is simply rotated in.
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            cnt_d   = cnt_q - CW'(1);
            out_d   = shreg_q[WIDTH-2];
          end else begin
            state_d = IDLE;
            frame_d = 1'b0;
            done_d  = 1'b1;
            out_d   = SDOUT_IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  comp_out_reg u_out (
    .clk   (clk),
    .reset (reset),
    .en    (out_en),
    .d     (out_d),
    .q     (sdout),
    .q_n   (sdout_n)
  );

endmodule
